// File: rtl/idu_pipe_pkg.sv
// Shared decode constants for the idu stage: one-hot op bit positions,
// major opcodes, funct7 patterns and bus widths.
package idu_pipe_pkg;

    localparam int REG_BUS      = 32;
    localparam int REG_ADDR_BUS = 5;

    // One-hot op positions on dec_info_bus_o. Bit 0 (OR) is relied on downstream.
    localparam int DEC_INFO_W = 20;
    localparam int DEC_OR     = 0;
    localparam int DEC_ADD    = 1;
    localparam int DEC_SUB    = 2;
    localparam int DEC_SLL    = 3;
    localparam int DEC_SLT    = 4;
    localparam int DEC_SLTU   = 5;
    localparam int DEC_XOR    = 6;
    localparam int DEC_SRL    = 7;
    localparam int DEC_SRA    = 8;
    localparam int DEC_AND    = 9;
    localparam int DEC_ADDI   = 10;
    localparam int DEC_SLTI   = 11;
    localparam int DEC_SLTIU  = 12;
    localparam int DEC_XORI   = 13;
    localparam int DEC_ORI    = 14;
    localparam int DEC_ANDI   = 15;
    localparam int DEC_SLLI   = 16;
    localparam int DEC_SRLI   = 17;
    localparam int DEC_SRAI   = 18;
    localparam int DEC_LUI    = 19;

    // Major opcodes, inst[6:2]
    localparam logic [4:0] OPC_OP    = 5'b01100;
    localparam logic [4:0] OPC_OPIMM = 5'b00100;
    localparam logic [4:0] OPC_LUI   = 5'b01101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        IMM_NONE  = 2'd0,
        IMM_I     = 2'd1,
        IMM_SHAMT = 2'd2,
        IMM_U     = 2'd3
    } imm_sel_e;

endpackage

// File: rtl/idu_pipe_dec.sv
// Purely combinational RV32I ALU-subset decoder: instruction word to one-hot
// op, immediate, illegal flag and rd write enable.
module idu_pipe_dec
    import idu_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]           inst,
    output logic [DEC_INFO_W-1:0] dec_info,
    output logic [XLEN-1:0]       imm,
    output logic                  illegal,
    output logic                  rd_we
);

    logic [4:0] opc;
    logic [2:0] funct3;
    logic [6:0] funct7;
    imm_sel_e   imm_sel;

    assign opc    = inst[6:2];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    // Exact-match decode; imm_sel is only set when an op actually matches,
    // so illegal encodings carry a zero immediate.
    always_comb begin
        dec_info = '0;
        imm_sel  = IMM_NONE;
        if (inst[1:0] == 2'b11) begin
            case (opc)
                OPC_OP: begin
                    case (funct3)
                        3'b000: begin
                            if (funct7 == F7_BASE)     dec_info[DEC_ADD] = 1'b1;
                            else if (funct7 == F7_ALT) dec_info[DEC_SUB] = 1'b1;
                        end
                        3'b001: dec_info[DEC_SLL]  = (funct7 == F7_BASE);
                        3'b010: dec_info[DEC_SLT]  = (funct7 == F7_BASE);
                        3'b011: dec_info[DEC_SLTU] = (funct7 == F7_BASE);
                        3'b100: dec_info[DEC_XOR]  = (funct7 == F7_BASE);
                        3'b101: begin
                            if (funct7 == F7_BASE)     dec_info[DEC_SRL] = 1'b1;
                            else if (funct7 == F7_ALT) dec_info[DEC_SRA] = 1'b1;
                        end
                        3'b110: dec_info[DEC_OR]   = (funct7 == F7_BASE);
                        3'b111: dec_info[DEC_AND]  = (funct7 == F7_BASE);
                    endcase
                end
                OPC_OPIMM: begin
                    case (funct3)
                        3'b000: begin dec_info[DEC_ADDI]  = 1'b1; imm_sel = IMM_I; end
                        3'b010: begin dec_info[DEC_SLTI]  = 1'b1; imm_sel = IMM_I; end
                        3'b011: begin dec_info[DEC_SLTIU] = 1'b1; imm_sel = IMM_I; end
                        3'b100: begin dec_info[DEC_XORI]  = 1'b1; imm_sel = IMM_I; end
                        3'b110: begin dec_info[DEC_ORI]   = 1'b1; imm_sel = IMM_I; end
                        3'b111: begin dec_info[DEC_ANDI]  = 1'b1; imm_sel = IMM_I; end
                        3'b001: begin
                            if (funct7 == F7_BASE) begin
                                dec_info[DEC_SLLI] = 1'b1;
                                imm_sel = IMM_SHAMT;
                            end
                        end
                        3'b101: begin
                            if (funct7 == F7_BASE) begin
                                dec_info[DEC_SRLI] = 1'b1;
                                imm_sel = IMM_SHAMT;
                            end else if (funct7 == F7_ALT) begin
                                dec_info[DEC_SRAI] = 1'b1;
                                imm_sel = IMM_SHAMT;
                            end
                        end
                    endcase
                end
                OPC_LUI: begin
                    dec_info[DEC_LUI] = 1'b1;
                    imm_sel = IMM_U;
                end
                default: ;
            endcase
        end
    end

    // Immediate formation; signed casts sign-extend to XLEN.
    always_comb begin
        case (imm_sel)
            IMM_I:     imm = XLEN'($signed(inst[31:20]));
            IMM_SHAMT: imm = XLEN'(inst[24:20]);
            IMM_U:     imm = XLEN'($signed({inst[31:12], 12'b0}));
            default:   imm = '0;
        endcase
    end

    assign illegal = ~|dec_info;
    assign rd_we   = ~illegal & (|inst[11:7]);

endmodule

// File: rtl/idu_pipe.sv
// Registered decode stage between ifu and exu with valid/ready on both sides,
// optional one-entry skid buffer and synchronous flush.
module idu_pipe
    import idu_pipe_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter bit SKID_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [31:0]           pc_i,
    input  logic [31:0]           inst_i,
    output logic [REG_AW-1:0]     rs1_addr_o,
    output logic [REG_AW-1:0]     rs2_addr_o,
    input  logic [XLEN-1:0]       rs1_data_i,
    input  logic [XLEN-1:0]       rs2_data_i,
    input  logic                  flush_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [31:0]           pc_o,
    output logic [XLEN-1:0]       rs1_data_o,
    output logic [XLEN-1:0]       rs2_data_o,
    output logic [XLEN-1:0]       imm_o,
    output logic [REG_AW-1:0]     rd_addr_o,
    output logic                  rd_we_o,
    output logic                  illegal_o,
    output logic [DEC_INFO_W-1:0] dec_info_bus_o
);

    typedef struct packed {
        logic [31:0]           pc;
        logic [XLEN-1:0]       rs1;
        logic [XLEN-1:0]       rs2;
        logic [XLEN-1:0]       imm;
        logic [REG_AW-1:0]     rd;
        logic                  rd_we;
        logic                  illegal;
        logic [DEC_INFO_W-1:0] dec_info;
    } payload_t;

    payload_t in_pl, out_pl, skid_pl;
    logic     out_valid, skid_valid;
    logic     out_valid_nxt, skid_valid_nxt;
    logic     in_fire, out_fire;
    logic     load_out, load_skid, skid_to_out;

    logic [DEC_INFO_W-1:0] dec_info;
    logic [XLEN-1:0]       dec_imm;
    logic                  dec_illegal, dec_rd_we;

    idu_pipe_dec #(.XLEN(XLEN)) u_dec (
        .inst     (inst_i),
        .dec_info (dec_info),
        .imm      (dec_imm),
        .illegal  (dec_illegal),
        .rd_we    (dec_rd_we)
    );

    assign rs1_addr_o = REG_AW'(inst_i[19:15]);
    assign rs2_addr_o = REG_AW'(inst_i[24:20]);

    assign in_pl.pc       = pc_i;
    assign in_pl.rs1      = rs1_data_i;
    assign in_pl.rs2      = rs2_data_i;
    assign in_pl.imm      = dec_imm;
    assign in_pl.rd       = REG_AW'(inst_i[11:7]);
    assign in_pl.rd_we    = dec_rd_we;
    assign in_pl.illegal  = dec_illegal;
    assign in_pl.dec_info = dec_info;

    // With the skid, ready depends only on a flop; without it, ready looks through to exu.
    assign in_ready_o = SKID_EN ? ~skid_valid : (~out_valid | out_ready_i);
    assign in_fire    = in_valid_i & in_ready_o;
    assign out_fire   = out_valid & out_ready_i;

    // Transfer steering: flush beats everything; a held skid entry drains before new input.
    always_comb begin
        load_out       = 1'b0;
        load_skid      = 1'b0;
        skid_to_out    = 1'b0;
        out_valid_nxt  = out_valid;
        skid_valid_nxt = skid_valid;
        if (flush_i) begin
            out_valid_nxt  = 1'b0;
            skid_valid_nxt = 1'b0;
        end else if (skid_valid) begin
            if (out_ready_i) begin
                skid_to_out    = 1'b1;
                skid_valid_nxt = 1'b0;
            end
        end else if (in_fire) begin
            if (out_valid & ~out_ready_i) begin
                load_skid      = 1'b1;
                skid_valid_nxt = 1'b1;
            end else begin
                load_out      = 1'b1;
                out_valid_nxt = 1'b1;
            end
        end else if (out_fire) begin
            out_valid_nxt = 1'b0;
        end
    end

    // Valid flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            out_valid  <= out_valid_nxt;
            skid_valid <= skid_valid_nxt;
        end
    end

    // Payload registers; not cleared by flush since valid gates them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pl  <= '0;
            skid_pl <= '0;
        end else begin
            if (load_out)         out_pl <= in_pl;
            else if (skid_to_out) out_pl <= skid_pl;
            if (load_skid)        skid_pl <= in_pl;
        end
    end

    assign out_valid_o    = out_valid;
    assign pc_o           = out_pl.pc;
    assign rs1_data_o     = out_pl.rs1;
    assign rs2_data_o     = out_pl.rs2;
    assign imm_o          = out_pl.imm;
    assign rd_addr_o      = out_pl.rd;
    assign rd_we_o        = out_pl.rd_we;
    assign illegal_o      = out_pl.illegal;
    assign dec_info_bus_o = out_pl.dec_info;

endmodule

// File: tb/tb_idu_pipe.sv
// Scoreboard bench: one skid and one no-skid instance fed the same instruction
// stream, each checked against a mask/match reference decoder.
module tb_idu_pipe;

    localparam logic [31:0] RM = 32'hFE00707F;
    localparam logic [31:0] IM = 32'h0000707F;
    localparam logic [31:0] UM = 32'h0000007F;

    // Reference encodings indexed by dec_info bit; kind 0=R 1=I 2=shamt 3=U
    localparam logic [31:0] MASK [20] = '{RM, RM, RM, RM, RM, RM, RM, RM, RM, RM,
                                          IM, IM, IM, IM, IM, IM, RM, RM, RM, UM};
    localparam logic [31:0] MATCH [20] = '{
        32'h00006033, 32'h00000033, 32'h40000033, 32'h00001033, 32'h00002033,
        32'h00003033, 32'h00004033, 32'h00005033, 32'h40005033, 32'h00007033,
        32'h00000013, 32'h00002013, 32'h00003013, 32'h00004013, 32'h00006013,
        32'h00007013, 32'h00001013, 32'h00005013, 32'h40005013, 32'h00000037};
    localparam int KIND [20] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                                 1, 1, 1, 1, 1, 1, 2, 2, 2, 3};

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
        logic [19:0] dec;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid [2];
    logic        in_ready [2];
    logic [31:0] pc, inst, rs1_d, rs2_d;
    logic        flush, out_ready;
    logic [4:0]  rs1_a [2];
    logic [4:0]  rs2_a [2];
    logic [4:0]  rd_a  [2];
    logic        out_valid [2];
    logic        rd_we [2];
    logic        ill [2];
    logic [31:0] pc_q [2];
    logic [31:0] rs1_q [2];
    logic [31:0] rs2_q [2];
    logic [31:0] imm_q [2];
    logic [19:0] dec_q [2];

    idu_pipe #(.XLEN(32), .REG_AW(5), .SKID_EN(1'b1)) u_skid (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .pc_i(pc), .inst_i(inst), .rs1_addr_o(rs1_a[0]), .rs2_addr_o(rs2_a[0]),
        .rs1_data_i(rs1_d), .rs2_data_i(rs2_d), .flush_i(flush),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready), .pc_o(pc_q[0]),
        .rs1_data_o(rs1_q[0]), .rs2_data_o(rs2_q[0]), .imm_o(imm_q[0]),
        .rd_addr_o(rd_a[0]), .rd_we_o(rd_we[0]), .illegal_o(ill[0]),
        .dec_info_bus_o(dec_q[0]));

    idu_pipe #(.XLEN(32), .REG_AW(5), .SKID_EN(1'b0)) u_noskid (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .pc_i(pc), .inst_i(inst), .rs1_addr_o(rs1_a[1]), .rs2_addr_o(rs2_a[1]),
        .rs1_data_i(rs1_d), .rs2_data_i(rs2_d), .flush_i(flush),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready), .pc_o(pc_q[1]),
        .rs1_data_o(rs1_q[1]), .rs2_data_o(rs2_q[1]), .imm_o(imm_q[1]),
        .rd_addr_o(rd_a[1]), .rd_we_o(rd_we[1]), .illegal_o(ill[1]),
        .dec_info_bus_o(dec_q[1]));

    int          n_chk = 0;
    int          n_pass = 0;
    int          fires [2];
    exp_t        sb [2][$];
    logic [31:0] stim_q [$];
    bit          pend [2];
    logic [31:0] rf [32];

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    endtask

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pcv,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.pc  = pcv;
        e.rs1 = a;
        e.rs2 = b;
        e.rd  = ins[11:7];
        e.dec = '0;
        e.imm = '0;
        for (int i = 0; i < 20; i++) begin
            if ((ins & MASK[i]) == MATCH[i]) begin
                e.dec[i] = 1'b1;
                case (KIND[i])
                    1:       e.imm = {{20{ins[31]}}, ins[31:20]};
                    2:       e.imm = {27'b0, ins[24:20]};
                    3:       e.imm = {ins[31:12], 12'b0};
                    default: e.imm = '0;
                endcase
            end
        end
        e.ill = (e.dec == '0);
        e.we  = !e.ill && (ins[11:7] != 5'd0);
        return e;
    endfunction

    function automatic logic [31:0] gen();
        int          i   = $urandom_range(0, 19);
        int          sel = $urandom_range(0, 9);
        logic [31:0] v   = ($urandom & ~MASK[i]) | MATCH[i];
        case (sel)
            6: v = $urandom;
            7: v[1:0] = 2'($urandom_range(0, 2));
            8: begin
                v = ($urandom & ~RM) | MATCH[16 + $urandom_range(0, 2)];
                v[31:25] = 7'($urandom);
            end
            9: v[11:7] = 5'd0;
            default: ;
        endcase
        return v;
    endfunction

    // Monitor: check held output against the scoreboard head, then apply this cycle's transfers.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                exp_t e;
                chk("rs1_addr", k, 32'(rs1_a[k]), 32'(inst[19:15]));
                chk("rs2_addr", k, 32'(rs2_a[k]), 32'(inst[24:20]));
                chk("out_valid", k, 32'(out_valid[k]), 32'(sb[k].size() != 0));
                if (k == 0) chk("in_ready_skid", k, 32'(in_ready[0]), 32'(sb[0].size() < 2));
                else        chk("in_ready_comb", k, 32'(in_ready[1]), 32'(!out_valid[1] || out_ready));
                if (out_valid[k] === 1'b1 && sb[k].size() != 0) begin
                    e = sb[k][0];
                    chk("pc", k, pc_q[k], e.pc);
                    chk("rs1_data", k, rs1_q[k], e.rs1);
                    chk("rs2_data", k, rs2_q[k], e.rs2);
                    chk("rd_addr", k, 32'(rd_a[k]), 32'(e.rd));
                    chk("rd_we", k, 32'(rd_we[k]), 32'(e.we));
                    chk("illegal", k, 32'(ill[k]), 32'(e.ill));
                    chk("dec_info", k, 32'(dec_q[k]), 32'(e.dec));
                    if (!e.ill) chk("imm", k, imm_q[k], e.imm);
                end
                if (flush) begin
                    sb[k].delete();
                end else begin
                    if (out_valid[k] && out_ready && sb[k].size() != 0) begin
                        void'(sb[k].pop_front());
                        fires[k]++;
                    end
                    if (in_valid[k] && in_ready[k])
                        sb[k].push_back(model(inst, pc, rs1_d, rs2_d));
                end
            end
        end
    end

    // One cycle of stimulus; a new instruction is offered once both instances took the last one.
    task automatic step(input bit rdy, input bit fl, input bit force_new);
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            if (flush || (in_valid[k] && in_ready[k])) pend[k] = 1'b0;
        @(posedge clk);
        #1;
        if ((force_new || (!pend[0] && !pend[1])) && stim_q.size() != 0) begin
            inst  = stim_q.pop_front();
            pc    = $urandom & 32'hFFFF_FFFC;
            rs1_d = rf[inst[19:15]];
            rs2_d = rf[inst[24:20]];
            pend  = '{1'b1, 1'b1};
        end
        in_valid[0] = pend[0];
        in_valid[1] = pend[1];
        flush       = fl;
        out_ready   = fl ? 1'b0 : rdy;
    endtask

    initial begin
        int f0, f1;
        rst_n = 1'b0;
        in_valid = '{1'b0, 1'b0};
        pend = '{1'b0, 1'b0};
        fires = '{0, 0};
        flush = 1'b0;
        out_ready = 1'b0;
        inst = '0;
        pc = '0;
        rs1_d = '0;
        rs2_d = '0;
        rf[0] = '0;
        for (int r = 1; r < 32; r++) rf[r] = $urandom;

        #12;
        for (int k = 0; k < 2; k++) begin
            chk("rst_out_valid", k, 32'(out_valid[k]), 32'd0);
            chk("rst_in_ready", k, 32'(in_ready[k]), 32'd1);
            chk("rst_pc", k, pc_q[k], 32'd0);
            chk("rst_dec", k, 32'(dec_q[k]), 32'd0);
            chk("rst_imm", k, imm_q[k], 32'd0);
            chk("rst_rd_we", k, 32'(rd_we[k]), 32'd0);
            chk("rst_illegal", k, 32'(ill[k]), 32'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Decode sweep
        stim_q = '{32'h0020E1B3, 32'h40208133, 32'hFFF00293, 32'h123453B7,
                   32'h4030D093, 32'h40109093, 32'h00208033};
        repeat (12) step(1'b1, 1'b0, 1'b0);

        // Backpressure: 4 instructions, exu stalls for 2 cycles
        stim_q = '{32'h0020E1B3, 32'h40208133, 32'hFFF00293, 32'h123453B7};
        repeat (2) step(1'b0, 1'b0, 1'b0);
        repeat (14) step(1'b1, 1'b0, 1'b0);

        // Throughput: 10 back-to-back instructions with exu always ready
        f0 = fires[0];
        f1 = fires[1];
        for (int i = 0; i < 10; i++) stim_q.push_back(gen());
        repeat (12) step(1'b1, 1'b0, 1'b0);
        chk("throughput", 0, 32'(fires[0] - f0), 32'd10);
        chk("throughput", 1, 32'(fires[1] - f1), 32'd10);

        // Flush with the skid full and a new instruction presented
        for (int i = 0; i < 3; i++) stim_q.push_back(gen());
        repeat (4) step(1'b0, 1'b0, 1'b0);
        chk("skid_full_ready", 0, 32'(in_ready[0]), 32'd0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            chk("flush_out_valid", k, 32'(out_valid[k]), 32'd0);
            chk("flush_in_ready", k, 32'(in_ready[k]), 32'd1);
        end
        stim_q.delete();
        repeat (4) step(1'b1, 1'b0, 1'b0);

        // Reset asserted mid-stream with output held valid
        stim_q = '{gen(), gen()};
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("pre_reset_valid", 0, 32'(out_valid[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async_rst_out_valid", k, 32'(out_valid[k]), 32'd0);
            chk("async_rst_in_ready", k, 32'(in_ready[k]), 32'd1);
            sb[k].delete();
        end
        stim_q.delete();
        pend = '{1'b0, 1'b0};
        in_valid = '{1'b0, 1'b0};
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) step(1'b1, 1'b0, 1'b0);

        // Randomised traffic with backpressure and occasional flushes
        repeat (1500) begin
            if (stim_q.size() == 0 && ($urandom % 4) != 0) stim_q.push_back(gen());
            step(($urandom % 10) < 7, ($urandom % 50) == 0, 1'b0);
        end
        repeat (10) step(1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
